// File: rtl/countdown_timer.sv
// MM:SS down-counter driven by a 1 Hz tick: loads a clamped preset, counts to 00:00,
// then pulses done for one cycle and holds alarm until ack, load or reset.
module countdown_timer #(
  parameter int MAX_SEC = 59,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       tick,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       ack,
  output logic [5:0] min_count,
  output logic [5:0] sec_count,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [5:0] SEC_TOP = 6'(MAX_SEC);
  localparam logic [5:0] MIN_TOP = 6'(MAX_MIN);

  state_t     state, state_nxt;
  logic [5:0] min_nxt, sec_nxt;
  logic [5:0] min_clamp, sec_clamp;
  logic       zero;

  assign min_clamp = (load_min > MIN_TOP) ? MIN_TOP : load_min;
  assign sec_clamp = (load_sec > SEC_TOP) ? SEC_TOP : load_sec;
  assign zero      = (min_count == 6'd0) && (sec_count == 6'd0);

  always_comb begin
    state_nxt = state;
    min_nxt   = min_count;
    sec_nxt   = sec_count;
    unique case (state)
      IDLE: begin
        if (load) begin
          min_nxt = min_clamp;
          sec_nxt = sec_clamp;
        end else if (!ack && !pause && start && !zero) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // load/ack/start carry no meaning here; pause beats a same-cycle tick
        if (pause) begin
          state_nxt = PAUSED;
        end else if (tick) begin
          if (sec_count != 6'd0) begin
            sec_nxt = sec_count - 6'd1;
            if (min_count == 6'd0 && sec_count == 6'd1) state_nxt = DONE;
          end else if (min_count != 6'd0) begin
            min_nxt = min_count - 6'd1;
            sec_nxt = SEC_TOP;
          end
        end
      end
      PAUSED: begin
        if (load) begin
          min_nxt   = min_clamp;
          sec_nxt   = sec_clamp;
          state_nxt = IDLE;
        end else if (!ack && !pause && start) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (load) begin
          min_nxt   = min_clamp;
          sec_nxt   = sec_clamp;
          state_nxt = IDLE;
        end else if (ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state     <= IDLE;
      min_count <= 6'd0;
      sec_count <= 6'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_nxt;
      min_count <= min_nxt;
      sec_count <= sec_nxt;
      running   <= (state_nxt == RUN);
      done      <= (state == RUN) && (state_nxt == DONE);
      alarm     <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one task per scenario, inline checks.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_p = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, ack = 1'b0;
  logic [5:0] load_min = '0, load_sec = '0;
  logic [5:0] min_count, sec_count;
  logic       running, done, alarm;

  int passed = 0;
  int total  = 0;

  countdown_timer #(.MAX_SEC(59), .MAX_MIN(59)) dut (
    .clk(clk), .rst_p(rst_p), .tick(tick), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause), .ack(ack),
    .min_count(min_count), .sec_count(sec_count), .running(running),
    .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    load_min = m; load_sec = s; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_p = 1'b1; step(); rst_p = 1'b0;
    total++;
    if ({min_count, sec_count, running, done, alarm} !== 15'd0)
      $display("FAIL reset_state got %0d:%0d r%b d%b a%b want 0:0 r0 d0 a0",
               min_count, sec_count, running, done, alarm);
    else passed++;
  endtask

  task automatic test_basic();
    do_load(6'd0, 6'd3);
    total++;
    if (min_count !== 6'd0 || sec_count !== 6'd3 || running !== 1'b0)
      $display("FAIL basic_load got %0d:%0d r%b want 0:3 r0", min_count, sec_count, running);
    else passed++;
    do_start();
    total++;
    if (running !== 1'b1) $display("FAIL basic_start running got %b want 1", running);
    else passed++;
    do_ticks(1);
    total++;
    if (sec_count !== 6'd2 || done !== 1'b0)
      $display("FAIL basic_tick1 got sec %0d d%b want 2 d0", sec_count, done);
    else passed++;
    do_ticks(1);
    total++;
    if (sec_count !== 6'd1) $display("FAIL basic_tick2 got sec %0d want 1", sec_count);
    else passed++;
    do_ticks(1);
    total++;
    if ({min_count, sec_count} !== 12'd0 || done !== 1'b1 || alarm !== 1'b1 || running !== 1'b0)
      $display("FAIL basic_zero got %0d:%0d d%b a%b r%b want 0:0 d1 a1 r0",
               min_count, sec_count, done, alarm, running);
    else passed++;
    do_ticks(1);
    total++;
    if (done !== 1'b0 || alarm !== 1'b1 || {min_count, sec_count} !== 12'd0)
      $display("FAIL basic_hold got %0d:%0d d%b a%b want 0:0 d0 a1", min_count, sec_count, done, alarm);
    else passed++;
    do_start();
    total++;
    if (alarm !== 1'b1 || running !== 1'b0)
      $display("FAIL done_start_ignored got a%b r%b want a1 r0", alarm, running);
    else passed++;
    ack = 1'b1; step(); ack = 1'b0;
    total++;
    if (alarm !== 1'b0 || done !== 1'b0 || running !== 1'b0)
      $display("FAIL basic_ack got a%b d%b r%b want a0 d0 r0", alarm, done, running);
    else passed++;
    do_start();
    total++;
    if (running !== 1'b0) $display("FAIL start_at_zero running got %b want 0", running);
    else passed++;
  endtask

  task automatic test_borrow();
    int pulses;
    do_load(6'd2, 6'd0);
    do_start();
    do_ticks(1);
    total++;
    if (min_count !== 6'd1 || sec_count !== 6'd59)
      $display("FAIL borrow_02_00 got %0d:%0d want 1:59", min_count, sec_count);
    else passed++;
    pause = 1'b1; step(); pause = 1'b0;
    do_load(6'd1, 6'd0);
    do_start();
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (done === 1'b1) pulses++;
    end
    step();
    if (done === 1'b1) pulses++;
    total++;
    if ({min_count, sec_count} !== 12'd0 || pulses != 1 || alarm !== 1'b1)
      $display("FAIL borrow_01_00 got %0d:%0d pulses %0d a%b want 0:0 pulses 1 a1",
               min_count, sec_count, pulses, alarm);
    else passed++;
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_pause();
    do_load(6'd0, 6'd10);
    do_start();
    do_ticks(2);
    total++;
    if (sec_count !== 6'd8) $display("FAIL pause_pre got sec %0d want 8", sec_count);
    else passed++;
    tick = 1'b1; pause = 1'b1; step(); tick = 1'b0; pause = 1'b0;
    total++;
    if (sec_count !== 6'd8 || running !== 1'b0)
      $display("FAIL pause_collide got sec %0d r%b want 8 r0", sec_count, running);
    else passed++;
    do_ticks(3);
    total++;
    if (sec_count !== 6'd8 || min_count !== 6'd0)
      $display("FAIL pause_hold got %0d:%0d want 0:8", min_count, sec_count);
    else passed++;
    do_start();
    do_ticks(1);
    total++;
    if (sec_count !== 6'd7 || running !== 1'b1)
      $display("FAIL pause_resume got sec %0d r%b want 7 r1", sec_count, running);
    else passed++;
  endtask

  task automatic test_clamp_and_ignored();
    do_load(6'd5, 6'd5);
    total++;
    if (min_count !== 6'd0 || sec_count !== 6'd7 || running !== 1'b1)
      $display("FAIL run_load_ignored got %0d:%0d r%b want 0:7 r1", min_count, sec_count, running);
    else passed++;
    pause = 1'b1; step(); pause = 1'b0;
    do_load(6'd63, 6'd60);
    total++;
    if (min_count !== 6'd59 || sec_count !== 6'd59 || running !== 1'b0)
      $display("FAIL clamp got %0d:%0d r%b want 59:59 r0", min_count, sec_count, running);
    else passed++;
    do_load(6'd3, 6'd61);
    total++;
    if (min_count !== 6'd3 || sec_count !== 6'd59)
      $display("FAIL clamp_sec_only got %0d:%0d want 3:59", min_count, sec_count);
    else passed++;
  endtask

  task automatic test_load_from_done();
    do_load(6'd0, 6'd1);
    do_start();
    do_ticks(1);
    total++;
    if (alarm !== 1'b1 || done !== 1'b1)
      $display("FAIL ldone_reach got a%b d%b want a1 d1", alarm, done);
    else passed++;
    step();
    do_load(6'd0, 6'd5);
    total++;
    if (sec_count !== 6'd5 || min_count !== 6'd0 || alarm !== 1'b0 || done !== 1'b0 || running !== 1'b0)
      $display("FAIL ldone_load got %0d:%0d a%b d%b r%b want 0:5 a0 d0 r0",
               min_count, sec_count, alarm, done, running);
    else passed++;
    do_ticks(2);
    total++;
    if (sec_count !== 6'd5) $display("FAIL ldone_idle_tick got sec %0d want 5", sec_count);
    else passed++;
  endtask

  task automatic test_reset_midcount();
    do_load(6'd1, 6'd30);
    do_start();
    do_ticks(5);
    total++;
    if (min_count !== 6'd1 || sec_count !== 6'd25)
      $display("FAIL mid_pre got %0d:%0d want 1:25", min_count, sec_count);
    else passed++;
    rst_p = 1'b1; step(); rst_p = 1'b0;
    total++;
    if ({min_count, sec_count} !== 12'd0 || running !== 1'b0 || alarm !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_reset got %0d:%0d r%b a%b d%b want 0:0 r0 a0 d0",
               min_count, sec_count, running, alarm, done);
    else passed++;
    do_ticks(3);
    total++;
    if ({min_count, sec_count} !== 12'd0 || running !== 1'b0)
      $display("FAIL mid_after got %0d:%0d r%b want 0:0 r0", min_count, sec_count, running);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_clamp_and_ignored();
    test_load_from_done();
    test_reset_midcount();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
